// File: rtl/rtmq_edge_pkg.sv
// Shared constants and helpers for the RTMQ edge timestamping block.
package rtmq_edge_pkg;

    localparam int W_DROP = 8;

    // Record layout is {ts, rise, fall}.
    function automatic int rec_width(input int w_ts, input int w_bus);
        return w_ts + 2 * w_bus;
    endfunction

endpackage

// File: rtl/rtmq_sync_fifo.sv
// Generic first-word-fall-through FIFO; the head entry is always visible on dout.
module rtmq_sync_fifo #(
    parameter int W = 8,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]  mem_reg [N];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   cnt_reg;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt_reg == (AW+1)'(N));
    assign empty = (cnt_reg == '0);
    assign dout  = mem_reg[rd_ptr_reg];

    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

endmodule

// File: rtl/rtmq_edge_stamp.sv
// Edge detector for synchronized inputs: stamps every change with a free-running
// counter and queues {ts, rise, fall} records for a valid/ready consumer.
module rtmq_edge_stamp
    import rtmq_edge_pkg::*;
#(
    parameter int W_BUS  = 1,
    parameter int W_TS   = 32,
    parameter int N_FIFO = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W_BUS-1:0]  din,
    input  logic              en,
    input  logic              clr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [W_TS-1:0]   evt_ts,
    output logic [W_BUS-1:0]  evt_rise,
    output logic [W_BUS-1:0]  evt_fall,
    output logic              ovf,
    output logic [W_DROP-1:0] drop_cnt
);

    localparam int W_REC = rec_width(W_TS, W_BUS);

    logic [W_BUS-1:0]  prv_reg;
    logic              primed_reg;
    logic [W_TS-1:0]   ts_reg;
    logic              ovf_reg;
    logic [W_DROP-1:0] drop_reg;

    logic [W_BUS-1:0]  rise;
    logic [W_BUS-1:0]  fall;
    logic              evt;
    logic              pop;
    logic              push;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [W_REC-1:0]  fifo_dout;

    assign rise = din & ~prv_reg;
    assign fall = ~din & prv_reg;
    assign evt  = primed_reg && en && (|(rise | fall));
    assign pop  = evt_valid && evt_ready;
    assign push = evt && !clr;
    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign drop = evt && !clr && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prv_reg    <= '0;
            primed_reg <= 1'b0;
            ts_reg     <= '0;
            ovf_reg    <= 1'b0;
            drop_reg   <= '0;
        end else if (clr) begin
            prv_reg    <= din;
            primed_reg <= 1'b0;
            ts_reg     <= '0;
            ovf_reg    <= 1'b0;
            drop_reg   <= '0;
        end else begin
            prv_reg    <= din;
            primed_reg <= 1'b1;
            ts_reg     <= ts_reg + 1'b1;
            if (drop) begin
                ovf_reg <= 1'b1;
                if (drop_reg != '1) begin
                    drop_reg <= drop_reg + 1'b1;
                end
            end
        end
    end

    rtmq_sync_fifo #(
        .W (W_REC),
        .N (N_FIFO)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (clr),
        .din   ({ts_reg, rise, fall}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign {evt_ts, evt_rise, evt_fall} = fifo_dout;
    assign ovf      = ovf_reg;
    assign drop_cnt = drop_reg;

endmodule
